// File: rtl/joydir_pkg.sv
// rtl/joydir_pkg.sv - shared types and helpers for the joystick direction filter
//
// Purpose: lane mode encoding, direction bit indices, the priority picker and
//          the per-mode direction mask used by every joydir_lane.
// Ports:   none (package).
// Config:  JOYDIR_DEBOUNCE_EN is consumed by joydir_lane, not by this package.
package joydir_pkg;

  typedef enum logic [1:0] {
    JD_PASS  = 2'b00,
    JD_WAY4  = 2'b01,
    JD_WAY2H = 2'b10,
    JD_WAY2V = 2'b11
  } joydir_mode_t;

  localparam int JD_UP    = 3;
  localparam int JD_DOWN  = 2;
  localparam int JD_LEFT  = 1;
  localparam int JD_RIGHT = 0;

  // One-hot of the highest set bit; up > down > left > right.
  function automatic logic [3:0] pri4(input logic [3:0] x);
    logic [3:0] r;
    r = 4'b0000;
    if (x[JD_UP])         r[JD_UP]    = 1'b1;
    else if (x[JD_DOWN])  r[JD_DOWN]  = 1'b1;
    else if (x[JD_LEFT])  r[JD_LEFT]  = 1'b1;
    else if (x[JD_RIGHT]) r[JD_RIGHT] = 1'b1;
    return r;
  endfunction

  // Directions a mode is allowed to report.
  function automatic logic [3:0] mode_mask(input joydir_mode_t m);
    logic [3:0] r;
    case (m)
      JD_WAY2H: r = 4'b0011;
      JD_WAY2V: r = 4'b1100;
      default:  r = 4'b1111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/joydir_lane.sv
// rtl/joydir_lane.sv - one player lane: optional debounce, sync, mask FSM, output register
//
// Purpose: cleans one player's raw U/D/L/R according to the run-time mode.
//          4-way style modes are newest-press-wins with fallback to a still-held
//          direction on release.
// Ports:   clk     - system clock
//          reset   - synchronous active-high reset
//          mode    - lane mode (joydir_mode_t encoding)
//          dir_in  - raw {up,down,left,right}, active-high
//          dir_out - filtered {up,down,left,right}, registered
// Config:  JOYDIR_DEBOUNCE_EN adds a per-bit stability counter of DEBOUNCE_CYCLES
//          ahead of the synchroniser.
module joydir_lane
  import joydir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [3:0] dir_in,
  output logic [3:0] dir_out
);

  logic [3:0] acc_dir;

`ifdef JOYDIR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [3:0]    db_q, db_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  // A bit is accepted only after it has differed from the accepted value for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old value restarts.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (dir_in[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]  = dir_in[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign acc_dir = db_q;
`else
  assign acc_dir = dir_in;
`endif

  logic [3:0]   s1_q, s1_d;
  logic [3:0]   s2_q, s2_d;
  logic [3:0]   mask_q, mask_d;
  logic [3:0]   out_q, out_d;
  joydir_mode_t mode_e;
  logic [3:0]   m;
  logic [3:0]   g;
  logic [3:0]   rise_m;

  always_comb begin
    mode_e = joydir_mode_t'(mode);
    m      = mode_mask(mode_e);
    s1_d   = acc_dir;
    s2_d   = s1_q;
    g      = s1_q & m;
    rise_m = s1_q & ~s2_q & m;

    mask_d = mask_q;
    if (mode_e == JD_PASS) begin
      mask_d = 4'b1111;
    end else if (rise_m != 4'b0000) begin
      mask_d = pri4(rise_m);
    end else if (((g & mask_q) == 4'b0000) || (mask_q == 4'b1111)) begin
      // Held direction released (or nothing grabbed yet): take a survivor.
      mask_d = (g != 4'b0000) ? pri4(g) : 4'b1111;
    end

    out_d = (mode_e == JD_PASS) ? s1_q : (g & mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 4'b0000;
      s2_q   <= 4'b0000;
      mask_q <= 4'b1111;
      out_q  <= 4'b0000;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      mask_q <= mask_d;
      out_q  <= out_d;
    end
  end

  assign dir_out = out_q;

endmodule

// File: rtl/joy_dir_filter.sv
// rtl/joy_dir_filter.sv - multi-player joystick direction filter top
//
// Purpose: NUM_PLAYERS independent joydir_lane instances with port slicing.
// Ports:   clk     - system clock
//          reset   - synchronous active-high reset
//          mode    - lane p mode at [2p+1:2p]: 00 PASS, 01 WAY4, 10 WAY2H, 11 WAY2V
//          dir_in  - lane p raw {up,down,left,right} at [4p+3:4p]
//          dir_out - lane p filtered directions, same packing, registered
// Config:  JOYDIR_DEBOUNCE_EN enables per-bit debounce of DEBOUNCE_CYCLES.
module joy_dir_filter
  import joydir_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*NUM_PLAYERS-1:0] mode,
  input  logic [4*NUM_PLAYERS-1:0] dir_in,
  output logic [4*NUM_PLAYERS-1:0] dir_out
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    joydir_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .mode   (mode[2*p +: 2]),
      .dir_in (dir_in[4*p +: 4]),
      .dir_out(dir_out[4*p +: 4])
    );
  end

endmodule
